// File: rtl/rca_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package rca_seq_pkg;

    // Controller states: waiting for operands, adding one nibble per cycle,
    // and holding the finished result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the single ripple-carry slice that is reused every cycle.
    localparam int SLICE_W = 4;

    // Number of slice cycles needed for an operand of the given width.
    function automatic int numSlices(input int width);
        return width / SLICE_W;
    endfunction

endpackage : rca_seq_pkg

// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle between a source/consumer and the sequencer.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    // Operand source and result consumer side.
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout
    );

endinterface : rca_seq_ctrl_if

// File: rtl/rca_seq_ctrl_nibble.sv
// Combinational 4-bit ripple-carry adder built from four full-adder stages.
module rca_nibble
    import rca_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] carryChain;

    assign carryChain[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]              = a[i] ^ b[i] ^ carryChain[i];
        assign carryChain[i + 1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
    end

    assign cout = carryChain[SLICE_W];

endmodule : rca_nibble

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple-carry slice is
// applied LSB first, with the carry held in a register between slices.
// WIDTH must be a multiple of 4 and at least 8.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    rca_seq_ctrl_if.slave                          bus,
    output logic                                   busy,
    output logic [$clog2(numSlices(WIDTH))-1:0]    slice_idx
);

    localparam int NSLICE = numSlices(WIDTH);
    localparam int IDX_W  = $clog2(NSLICE);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [IDX_W-1:0]   slice_idx_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic               out_cout_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    logic [SLICE_W-1:0] sliceSum;
    logic               sliceCout;

    // The single shared slice always looks at the low nibble of each shift
    // register plus the carry left over from the previous slice.
    rca_nibble u_nibble (
        .a    (a_sh_q[SLICE_W-1:0]),
        .b    (b_sh_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (sliceSum),
        .cout (sliceCout)
    );

    // Controller FSM with all datapath state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            slice_idx_q <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_q      <= bus.in_a;
                        b_sh_q      <= bus.in_b;
                        carry_q     <= bus.in_cin;
                        out_sum_q   <= '0;
                        slice_idx_q <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    out_sum_q[SLICE_W*slice_idx_q +: SLICE_W] <= sliceSum;
                    carry_q     <= sliceCout;
                    a_sh_q      <= a_sh_q >> SLICE_W;
                    b_sh_q      <= b_sh_q >> SLICE_W;
                    slice_idx_q <= slice_idx_q + 1'b1;
                    if (slice_idx_q == IDX_W'(NSLICE - 1)) begin
                        out_cout_q  <= sliceCout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign busy          = busy_q;
    assign slice_idx     = slice_idx_q;

endmodule : rca_seq_ctrl

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for the nibble-serial adder sequencer (WIDTH=16).
module tb_rca_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] slice_idx;

    int testCount = 0;
    int failCount = 0;

    rca_seq_ctrl_if #(.WIDTH(16)) bus ();

    rca_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .slice_idx (slice_idx)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full operation from IDLE with out_ready already high: accept,
    // count cycles to out_valid, check result, then check return to IDLE.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [15:0] expSum, input logic expCout);
        int cycles;
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'hDEAD;
        bus.in_b     = 16'hBEEF;
        checkOutput({tag, "_sum_cleared"}, 32'(bus.out_sum), 32'h0);
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd4);
        checkOutput({tag, "_sum"}, 32'(bus.out_sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(bus.out_cout), 32'(expCout));
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cycles;
        int cyc;
        int accCount;
        int resCount;
        int accCycle [2];
        logic [15:0] opA  [2];
        logic [15:0] opB  [2];
        logic [15:0] expS [2];
        logic        expC [2];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values while reset is still held.
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(bus.out_sum), 32'h0);
        checkOutput("rst_out_cout", 32'(bus.out_cout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_slice_idx", 32'(slice_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic additions and carry boundaries.
        applyStimulus("t1", 16'h0006, 16'h0005, 1'b0, 16'h000B, 1'b0);
        applyStimulus("t2a", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus("t2b", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        applyStimulus("t3a", 16'h0000, 16'h0001, 1'b1, 16'h0002, 1'b0);
        applyStimulus("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: result held for 5 cycles, new operands ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h0123;
        bus.in_b      = 16'h0456;
        bus.in_cin    = 1'b0;
        @(negedge clk);
        bus.in_a = 16'hAAAA;
        bus.in_b = 16'h5555;
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("t4_latency", 32'(cycles), 32'd4);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("t4_hold_sum", 32'(bus.out_sum), 32'h0579);
            checkOutput("t4_hold_cout", 32'(bus.out_cout), 32'd0);
            checkOutput("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("t4_pre_handshake_sum", 32'(bus.out_sum), 32'h0579);
        @(negedge clk);
        checkOutput("t4_valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("t4_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of RUN discards everything.
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h2222;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t5_slice_idx", 32'(slice_idx), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("t5_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t5_out_sum", 32'(bus.out_sum), 32'h0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_slice_idx_clr", 32'(slice_idx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t5_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Back-to-back with in_valid held high.
        opA[0] = 16'h1234; opB[0] = 16'h1111; expS[0] = 16'h2345; expC[0] = 1'b0;
        opA[1] = 16'hF000; opB[1] = 16'h1000; expS[1] = 16'h0000; expC[1] = 1'b1;
        accCount = 0;
        resCount = 0;
        cyc = 0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        while (resCount < 2 && cyc < 40) begin
            if (accCount < 2) begin
                bus.in_valid = 1'b1;
                bus.in_a     = opA[accCount];
                bus.in_b     = opB[accCount];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                checkOutput("t6_sum", 32'(bus.out_sum), 32'(expS[resCount]));
                checkOutput("t6_cout", 32'(bus.out_cout), 32'(expC[resCount]));
                resCount++;
            end
            if (bus.in_ready && bus.in_valid) begin
                accCycle[accCount] = cyc;
                accCount++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checkOutput("t6_results", 32'(resCount), 32'd2);
        checkOutput("t6_accepts", 32'(accCount), 32'd2);
        if (accCount == 2)
            checkOutput("t6_spacing", 32'(accCycle[1] - accCycle[0]), 32'd6);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_rca_seq_ctrl
